// File: rtl/ot_pkg.sv
// Shared definitions for the OT filter driver: geometry, widths, state encoding
// and error-flag bit positions.
package ot_pkg;

    localparam int NPIX        = 75;   // 5 wide x 15 rows, raster order
    localparam int PIX_W       = 8;    // frame pixel width
    localparam int RES_W       = 12;   // filtered result width (8.4 fixed point)
    localparam int ADDR_W      = 7;    // covers 0..NPIX-1
    localparam int TIMEOUT_DEF = 255;  // default WAIT budget before first result

    // Bit positions inside the sticky err vector
    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_SHORT   = 1;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        RECV,
        DONE
    } state_t;

endpackage

// File: rtl/ot_drv_buf.sv
// Single-write / single-registered-read storage array used for both the frame
// buffer (8-bit) and the result buffer (12-bit). Out-of-range writes are
// dropped; out-of-range or disabled reads return zero. With BYPASS set, a read
// of the entry being written in the same cycle returns the new data, otherwise
// it returns the old contents.
module ot_drv_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 75,
    parameter int ADDR_W = 7,
    parameter bit BYPASS = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write port; addresses beyond DEPTH are ignored
    // NOTE: the array has no reset on purpose so it maps onto RAM; only the read register is reset.
    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port, zero when disabled or out of range
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re && (int'(raddr) < DEPTH)) begin
            if (BYPASS && we && (waddr == raddr)) begin
                rdata <= wdata;
            end else begin
                rdata <= mem[raddr];
            end
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/ot_driver.sv
// Initiator for the OT 3x3 smoothing filter. The host loads a 75-pixel frame,
// pulses start, the frame is streamed to the filter as one gap-free burst, and
// the 75 filtered results are captured into a result buffer for read-back.
// Optional feature: define OT_DRV_CHECKSUM_EN to add a 16-bit running sum of
// the stored result beats on the checksum output.
module ot_driver
    import ot_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [6:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        start,
    input  logic [6:0]  rd_addr,
    output logic [11:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic        ot_in_valid,
    output logic [7:0]  ot_image_in,
    input  logic        ot_out_valid,
    input  logic [11:0] ot_image_out
`ifdef OT_DRV_CHECKSUM_EN
    ,
    output logic [15:0] checksum
`endif
);

    localparam int                TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]     TMAX = TW'(TIMEOUT);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    state_t             state;
    logic [ADDR_W-1:0]  scnt;      // index of the beat currently on ot_image_in
    logic [ADDR_W-1:0]  rcnt;      // next result slot to fill
    logic [TW-1:0]      tcnt;      // cycles spent in WAIT
    logic               ov_q;      // filter out_valid, registered at the pins
    logic [RES_W-1:0]   od_q;      // filter image_out, registered at the pins

    logic               fb_we;
    logic               fb_re;
    logic [ADDR_W-1:0]  fb_raddr;
    logic               rb_we;

    // Buffer port control: host writes only in IDLE, frame reads run one beat
    // ahead of the output so each pixel lands on ot_image_in on time
    // NOTE: every signal gets a default at the top so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        fb_we    = (state == IDLE) && wr_en;
        fb_re    = 1'b0;
        fb_raddr = '0;
        if (state == IDLE) begin
            fb_re = start;
        end else if ((state == SEND) && (scnt != LAST)) begin
            fb_re    = 1'b1;
            fb_raddr = scnt + ONE;
        end
        rb_we = ((state == WAIT) || (state == RECV)) && ov_q;
    end

    // Frame buffer: its read register drives the filter pixel input directly.
    // Bypass lets a write coincident with start reach beat 0.
    ot_drv_buf #(
        .DATA_W (PIX_W),
        .DEPTH  (NPIX),
        .ADDR_W (ADDR_W),
        .BYPASS (1'b1)
    ) u_fbuf (
        .clk   (clk),
        .rst   (rst),
        .we    (fb_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (fb_re),
        .raddr (fb_raddr),
        .rdata (ot_image_in)
    );

    // Result buffer: filled from the registered filter outputs, read by the host
    ot_drv_buf #(
        .DATA_W (RES_W),
        .DEPTH  (NPIX),
        .ADDR_W (ADDR_W),
        .BYPASS (1'b0)
    ) u_rbuf (
        .clk   (clk),
        .rst   (rst),
        .we    (rb_we),
        .waddr (rcnt),
        .wdata (od_q),
        .re    (1'b1),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Register the filter outputs at the pins before any decision is made
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_q <= 1'b0;
            od_q <= '0;
        end else begin
            ov_q <= ot_out_valid;
            od_q <= ot_image_out;
        end
    end

    // Run sequencer: send burst, wait for first result, receive, report
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            scnt        <= '0;
            rcnt        <= '0;
            tcnt        <= '0;
            ot_in_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= SEND;
                        busy        <= 1'b1;
                        ot_in_valid <= 1'b1;
                        err         <= '0;
                        scnt        <= '0;
                        rcnt        <= '0;
                    end
                end
                SEND: begin
                    if (scnt == LAST) begin
                        state       <= WAIT;
                        ot_in_valid <= 1'b0;
                        tcnt        <= '0;
                    end else begin
                        scnt <= scnt + ONE;
                    end
                end
                WAIT: begin
                    if (ov_q) begin
                        rcnt  <= ONE;
                        state <= RECV;
                    end else if (tcnt == TMAX) begin
                        err[ERR_TIMEOUT] <= 1'b1;
                        done             <= 1'b1;
                        state            <= DONE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                RECV: begin
                    if (ov_q) begin
                        if (rcnt == LAST) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            rcnt <= rcnt + ONE;
                        end
                    end else begin
                        err[ERR_SHORT] <= 1'b1;
                        done           <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef OT_DRV_CHECKSUM_EN
    // Running modulo-2^16 sum of every result beat stored in the current run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if ((state == IDLE) && start) begin
            checksum <= '0;
        end else if (rb_we) begin
            checksum <= checksum + 16'(od_q);
        end
    end
`endif

endmodule

// File: tb/tb_ot_driver.sv
// Directed bench for ot_driver: reset values, full send/receive run, timeout,
// short result burst, trailing extra beat, reset during SEND with replay.
// Build with OT_DRV_CHECKSUM_EN defined to also exercise the checksum output.
module tb_ot_driver;

    localparam int NPIX    = 75;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [6:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        start = 1'b0;
    logic [6:0]  rd_addr = '0;
    logic [11:0] rd_data;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic        ot_in_valid;
    logic [7:0]  ot_image_in;
    logic        ot_out_valid = 1'b0;
    logic [11:0] ot_image_out = '0;
`ifdef OT_DRV_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [7:0] cap_data [NPIX];
    logic       cap_valid [NPIX];

    ot_driver dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .start        (start),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .ot_in_valid  (ot_in_valid),
        .ot_image_in  (ot_image_in),
        .ot_out_valid (ot_out_valid),
        .ot_image_out (ot_image_out)
`ifdef OT_DRV_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Advance to the next falling edge, where outputs are sampled and inputs driven
    task automatic tick();
        @(negedge clk);
        if (done) done_cnt++;
    endtask

    task automatic host_write(input logic [6:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Pulse start (optionally with a coincident write); returns with beat 0 visible
    task automatic pulse_start(input logic with_wr, input logic [6:0] a, input logic [7:0] d);
        start = 1'b1; wr_en = with_wr; wr_addr = a; wr_data = d;
        tick();
        start = 1'b0; wr_en = 1'b0;
    endtask

    // Record the whole burst; returns at the cycle where ot_in_valid should have fallen
    task automatic capture_burst();
        for (int i = 0; i < NPIX; i++) begin
            cap_data[i]  = ot_image_in;
            cap_valid[i] = ot_in_valid;
            tick();
        end
    endtask

    // Drive n contiguous result beats base+i; beat index 75 carries 0xFFF
    task automatic drive_beats(input int n, input logic [11:0] base);
        for (int i = 0; i < n; i++) begin
            ot_out_valid = 1'b1;
            ot_image_out = (i == NPIX) ? 12'hFFF : base + 12'(i);
            tick();
        end
        ot_out_valid = 1'b0;
        ot_image_out = '0;
    endtask

    task automatic read_result(input logic [6:0] a, output logic [11:0] v);
        rd_addr = a;
        tick();
        v = rd_data;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        int k = 0;
        while (!done && k < budget) begin
            tick();
            k++;
        end
        seen = done;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_total++; if (ot_in_valid !== 1'b0) $display("FAIL rst_in_valid got %b exp 0", ot_in_valid); else n_pass++;
        n_total++; if (ot_image_in !== 8'h00) $display("FAIL rst_image_in got %h exp 00", ot_image_in); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rst_done got %b exp 0", done); else n_pass++;
        n_total++; if (err !== 2'b00) $display("FAIL rst_err got %b exp 00", err); else n_pass++;
        n_total++; if (rd_data !== 12'h000) $display("FAIL rst_rd_data got %h exp 000", rd_data); else n_pass++;
`ifdef OT_DRV_CHECKSUM_EN
        n_total++; if (checksum !== 16'h0000) $display("FAIL rst_checksum got %h exp 0000", checksum); else n_pass++;
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_run();
        logic [11:0] v;
        for (int i = 0; i < NPIX; i++) host_write(7'(i), 8'(i));
        host_write(7'd100, 8'hAA);
        done_cnt = 0;
        pulse_start(1'b0, '0, '0);
        n_total++; if (busy !== 1'b1) $display("FAIL full_busy_rise got %b exp 1", busy); else n_pass++;
        capture_burst();
        for (int i = 0; i < NPIX; i++) begin
            n_total++;
            if (cap_valid[i] !== 1'b1 || cap_data[i] !== 8'(i))
                $display("FAIL full_beat%0d got v=%b d=%h exp v=1 d=%h", i, cap_valid[i], cap_data[i], 8'(i));
            else n_pass++;
        end
        n_total++; if (ot_in_valid !== 1'b0 || ot_image_in !== 8'h00)
            $display("FAIL full_send_end got v=%b d=%h exp v=0 d=00", ot_in_valid, ot_image_in); else n_pass++;
        tick(); tick(); tick();
        drive_beats(NPIX, 12'h000);
        tick();
        n_total++; if (done !== 1'b1 || busy !== 1'b1) $display("FAIL full_done_edge got done=%b busy=%b exp 1 1", done, busy); else n_pass++;
        tick();
        n_total++; if (busy !== 1'b0) $display("FAIL full_busy_fall got %b exp 0", busy); else n_pass++;
        for (int i = 0; i < 8; i++) tick();
        n_total++; if (done_cnt !== 1) $display("FAIL full_done_count got %0d exp 1", done_cnt); else n_pass++;
        n_total++; if (err !== 2'b00) $display("FAIL full_err got %b exp 00", err); else n_pass++;
        read_result(7'd10, v);
        n_total++; if (v !== 12'h00A) $display("FAIL full_rd10 got %h exp 00A", v); else n_pass++;
        read_result(7'd74, v);
        n_total++; if (v !== 12'h04A) $display("FAIL full_rd74 got %h exp 04A", v); else n_pass++;
        read_result(7'd100, v);
        n_total++; if (v !== 12'h000) $display("FAIL full_rd_oob got %h exp 000", v); else n_pass++;
`ifdef OT_DRV_CHECKSUM_EN
        n_total++; if (checksum !== 16'h0AD7) $display("FAIL full_checksum got %h exp 0AD7", checksum); else n_pass++;
`endif
    endtask

    task automatic test_timeout();
        int w_cyc;
        bit seen;
        done_cnt = 0;
        pulse_start(1'b0, '0, '0);
        capture_burst();
        w_cyc = cyc;
        n_total++; if (ot_in_valid !== 1'b0) $display("FAIL to_send_end got %b exp 0", ot_in_valid); else n_pass++;
        wait_done(400, seen);
        n_total++; if (!seen) $display("FAIL to_done_seen got 0 exp 1 within 400 cycles"); else n_pass++;
        n_total++; if (cyc - w_cyc !== TIMEOUT + 1) $display("FAIL to_done_delay got %0d exp %0d", cyc - w_cyc, TIMEOUT + 1); else n_pass++;
        n_total++; if (err !== 2'b01) $display("FAIL to_err got %b exp 01", err); else n_pass++;
        for (int i = 0; i < 4; i++) tick();
        n_total++; if (done_cnt !== 1 || busy !== 1'b0) $display("FAIL to_after got done_cnt=%0d busy=%b exp 1 0", done_cnt, busy); else n_pass++;
    endtask

    task automatic test_short_burst();
        logic [11:0] v;
        bit seen;
        done_cnt = 0;
        pulse_start(1'b0, '0, '0);
        capture_burst();
        tick(); tick();
        drive_beats(40, 12'h100);
        wait_done(10, seen);
        n_total++; if (!seen) $display("FAIL short_done_seen got 0 exp 1 within 10 cycles"); else n_pass++;
        n_total++; if (err !== 2'b10) $display("FAIL short_err got %b exp 10", err); else n_pass++;
        for (int i = 0; i < 4; i++) tick();
        n_total++; if (done_cnt !== 1) $display("FAIL short_done_count got %0d exp 1", done_cnt); else n_pass++;
        read_result(7'd39, v);
        n_total++; if (v !== 12'h127) $display("FAIL short_rd39 got %h exp 127", v); else n_pass++;
        read_result(7'd40, v);
        n_total++; if (v !== 12'h028) $display("FAIL short_rd40 got %h exp 028", v); else n_pass++;
`ifdef OT_DRV_CHECKSUM_EN
        // 40*0x100 + sum(0..39) = 0x2800 + 0x30C
        n_total++; if (checksum !== 16'h2B0C) $display("FAIL short_checksum got %h exp 2B0C", checksum); else n_pass++;
`endif
    endtask

    task automatic test_back_to_back();
        logic [11:0] v;
        done_cnt = 0;
        pulse_start(1'b0, '0, '0);
        // writes and start while busy must be ignored
        tick();
        wr_en = 1'b1; wr_addr = 7'd5; wr_data = 8'hEE; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        for (int i = 0; i < NPIX - 2; i++) tick();
        tick();
        drive_beats(NPIX + 1, 12'h000);
        for (int i = 0; i < 10; i++) tick();
        n_total++; if (done_cnt !== 1) $display("FAIL b2b_done_count got %0d exp 1", done_cnt); else n_pass++;
        n_total++; if (err !== 2'b00) $display("FAIL b2b_err got %b exp 00", err); else n_pass++;
        read_result(7'd74, v);
        n_total++; if (v !== 12'h04A) $display("FAIL b2b_rd74 got %h exp 04A", v); else n_pass++;
        read_result(7'd0, v);
        n_total++; if (v !== 12'h000) $display("FAIL b2b_rd0 got %h exp 000", v); else n_pass++;
`ifdef OT_DRV_CHECKSUM_EN
        n_total++; if (checksum !== 16'h0AD7) $display("FAIL b2b_checksum got %h exp 0AD7", checksum); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid_run();
        pulse_start(1'b0, '0, '0);
        for (int i = 0; i < 20; i++) tick();
        n_total++; if (ot_image_in !== 8'd20) $display("FAIL mid_beat20 got %h exp 14", ot_image_in); else n_pass++;
        rst = 1'b1;
        tick();
        n_total++; if (ot_in_valid !== 1'b0 || busy !== 1'b0 || ot_image_in !== 8'h00 || err !== 2'b00)
            $display("FAIL mid_rst_outputs got v=%b busy=%b d=%h err=%b exp 0 0 00 00", ot_in_valid, busy, ot_image_in, err);
        else n_pass++;
        rst = 1'b0;
        tick();
        // start coincident with a write to pixel 0: the new byte must be beat 0
        pulse_start(1'b1, 7'd0, 8'h55);
        capture_burst();
        for (int i = 0; i < NPIX; i++) begin
            n_total++;
            if (cap_valid[i] !== 1'b1 || cap_data[i] !== ((i == 0) ? 8'h55 : 8'(i)))
                $display("FAIL replay_beat%0d got v=%b d=%h exp v=1 d=%h", i, cap_valid[i], cap_data[i], (i == 0) ? 8'h55 : 8'(i));
            else n_pass++;
        end
        n_total++; if (ot_in_valid !== 1'b0) $display("FAIL replay_end got %b exp 0", ot_in_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_timeout();
        test_short_burst();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
